fpu_mult_request_ctrl: RTL and testbench

Initiator-side controller for the floating-point multiplication unit's start/ready protocol. It accepts operand pairs on a valid/ready input channel and drives the unit's operands and round mode. It pulses beg_FSM, waits for ready_flag with a timeout, captures the result and flags, then pulses rst_FSM to release the unit. The captured result is presented on a valid/ready output channel. It sits between the operand source (bus/sequencer) and the multiplication unit.

---
 rtl/fpu_mult_request_ctrl.sv | 120 ++++++++++++
 tb/tb_fpu_mult_request_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_mult_request_ctrl.sv
// Initiator-side controller for the FP multiply unit: accepts operand pairs, runs the
// beg_FSM / ready_flag / rst_FSM handshake with a timeout, and presents the captured result.
module fpu_mult_request_ctrl #(
  parameter int unsigned W       = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_x,
  input  logic [W-1:0] in_y,
  input  logic [1:0]   in_round,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic         out_overflow,
  output logic         out_underflow,
  output logic         out_timeout,
  output logic         beg_FSM,
  output logic         rst_FSM,
  output logic [W-1:0] Data_MX,
  output logic [W-1:0] Data_MY,
  output logic [1:0]   round_mode,
  input  logic         ready_flag,
  input  logic [W-1:0] F_ieee_result,
  input  logic         overflow_flag,
  input  logic         underflow_flag,
  output logic         busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    RELEASE,
    OUTPUT
  } state_t;

  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  state_t      state_next;
  logic [15:0] timer;
  logic        accept;
  logic        expired;

  assign accept  = in_valid & in_ready;
  assign expired = (timer == TIMER_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = START;
      START:   state_next = WAIT;
      WAIT:    if (ready_flag || expired) state_next = RELEASE;
      RELEASE: state_next = OUTPUT;
      OUTPUT:  if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    beg_FSM   = (state == START);
    rst_FSM   = (state == RELEASE);
    out_valid = (state == OUTPUT);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Data_MX    <= '0;
      Data_MY    <= '0;
      round_mode <= '0;
    end else if (accept) begin
      Data_MX    <= in_x;
      Data_MY    <= in_y;
      round_mode <= in_round;
    end
  end

  // ready_flag takes priority over expiry, so a result arriving on the last WAIT cycle is kept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer         <= '0;
      out_result    <= '0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
      out_timeout   <= 1'b0;
    end else begin
      if (state == START) begin
        timer <= '0;
      end else if (state == WAIT) begin
        if (ready_flag) begin
          out_result    <= F_ieee_result;
          out_overflow  <= overflow_flag;
          out_underflow <= underflow_flag;
          out_timeout   <= 1'b0;
        end else if (expired) begin
          out_result    <= '0;
          out_overflow  <= 1'b0;
          out_underflow <= 1'b0;
          out_timeout   <= 1'b1;
        end else begin
          timer <= timer + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fpu_mult_request_ctrl.sv
// Bench for fpu_mult_request_ctrl: stub multiply unit, relative-time behavioural model, directed ops.
module tb_fpu_mult_request_ctrl;
  localparam int W  = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_x = '0;
  logic [W-1:0]  in_y = '0;
  logic [1:0]    in_round = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_result;
  logic          out_overflow, out_underflow, out_timeout;
  logic          beg_FSM, rst_FSM;
  logic [W-1:0]  Data_MX, Data_MY;
  logic [1:0]    round_mode;
  logic          ready_flag = 1'b0;
  logic [W-1:0]  F_ieee_result = '0;
  logic          overflow_flag = 1'b0;
  logic          underflow_flag = 1'b0;
  logic          busy;

  fpu_mult_request_ctrl #(.W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_round(in_round),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_overflow(out_overflow),
    .out_underflow(out_underflow), .out_timeout(out_timeout),
    .beg_FSM(beg_FSM), .rst_FSM(rst_FSM),
    .Data_MX(Data_MX), .Data_MY(Data_MY), .round_mode(round_mode),
    .ready_flag(ready_flag), .F_ieee_result(F_ieee_result),
    .overflow_flag(overflow_flag), .underflow_flag(underflow_flag),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Stub multiply unit: raises ready_flag stub_delay cycles after beg_FSM, holds it until rst_FSM.
  int           stub_delay = -1;
  logic [W-1:0] stub_f = '0;
  logic         stub_ov = 1'b0;
  logic         stub_un = 1'b0;
  int           stub_cnt = -1;

  always @(posedge clk) begin
    #1;
    if (!rst || rst_FSM) begin
      stub_cnt       = -1;
      ready_flag     = 1'b0;
      F_ieee_result  = '0;
      overflow_flag  = 1'b0;
      underflow_flag = 1'b0;
    end else begin
      if (beg_FSM) stub_cnt = 0;
      else if (stub_cnt >= 0) stub_cnt++;
      if (stub_cnt >= 0 && stub_cnt == stub_delay) begin
        ready_flag     = 1'b1;
        F_ieee_result  = stub_f;
        overflow_flag  = stub_ov;
        underflow_flag = stub_un;
      end
    end
  end

  // Pulse counters and cycle stamps for the literal expectations.
  int   beg_cnt = 0, rst_cnt = 0, beg_cyc = 0, rst_cyc = 0, rdy_cyc = 0, ov_cyc = 0;
  logic rdy_q = 1'b0, ov_q = 1'b0;

  always @(negedge clk) begin
    if (beg_FSM) begin beg_cnt++; beg_cyc = cyc; end
    if (rst_FSM) begin rst_cnt++; rst_cyc = cyc; end
    if (ready_flag && !rdy_q) rdy_cyc = cyc;
    if (out_valid && !ov_q) ov_cyc = cyc;
    rdy_q = ready_flag;
    ov_q  = out_valid;
  end

  // Model: n counts cycles since accept; done_n is the WAIT cycle where the op resolved.
  bit           m_active = 0;
  int           m_n = 0;
  int           m_done = -1;
  logic [W-1:0] e_mx = '0, e_my = '0, e_res = '0;
  logic [1:0]   e_rnd = '0;
  logic         e_ov = 0, e_un = 0, e_to = 0;

  always @(negedge clk) begin
    bit e_beg, e_rel, e_ov_valid;
    if (!rst) begin
      m_active = 0; m_n = 0; m_done = -1;
      e_mx = '0; e_my = '0; e_res = '0; e_rnd = '0;
      e_ov = 0; e_un = 0; e_to = 0;
    end else begin
      e_beg      = m_active && m_n == 1;
      e_rel      = m_active && m_done >= 0 && m_n == m_done + 1;
      e_ov_valid = m_active && m_done >= 0 && m_n >= m_done + 2;
      check("model in_ready", in_ready, !m_active);
      check("model busy", busy, m_active);
      check("model beg_FSM", beg_FSM, e_beg);
      check("model rst_FSM", rst_FSM, e_rel);
      check("model out_valid", out_valid, e_ov_valid);
      check("model Data_MX", Data_MX, e_mx);
      check("model Data_MY", Data_MY, e_my);
      check("model round_mode", round_mode, e_rnd);
      check("model out_result", out_result, e_res);
      check("model out_overflow", out_overflow, e_ov);
      check("model out_underflow", out_underflow, e_un);
      check("model out_timeout", out_timeout, e_to);
      if (!m_active) begin
        if (in_valid) begin
          m_active = 1; m_n = 1; m_done = -1;
          e_mx = in_x; e_my = in_y; e_rnd = in_round;
        end
      end else begin
        if (m_done < 0 && m_n >= 2) begin
          if (ready_flag) begin
            m_done = m_n;
            e_res = F_ieee_result; e_ov = overflow_flag; e_un = underflow_flag; e_to = 0;
          end else if (m_n - 1 == TO) begin
            m_done = m_n;
            e_res = '0; e_ov = 0; e_un = 0; e_to = 1;
          end
        end
        if (e_ov_valid && out_ready) m_active = 0;
        m_n++;
      end
    end
  end

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic [1:0] r,
                        input int dly, input logic [W-1:0] f, input logic ov, input logic un,
                        input int bp);
    bit ok;
    @(posedge clk); #1;
    stub_delay = dly; stub_f = f; stub_ov = ov; stub_un = un;
    beg_cnt = 0; rst_cnt = 0;
    out_ready = (bp == 0);
    in_x = x; in_y = y; in_round = r; in_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) check("accept timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_x = ~x; in_y = ~y;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1; break; end
    end
    if (!ok) check("out_valid timeout", 0, 1);
    #1;
    if (bp > 0) begin
      in_valid = 1'b1;
      repeat (bp) begin
        @(posedge clk); #1;
        check("bp result stable", out_result, f);
        check("bp in_ready low", in_ready, 0);
      end
      out_ready = 1'b1;
      in_valid  = 1'b0;
    end
    @(posedge clk); #1;
    check("in_ready after output", in_ready, 1);
    check("one beg pulse", beg_cnt, 1);
    check("one rst pulse", rst_cnt, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset beg_FSM", beg_FSM, 0);
    check("reset busy", busy, 0);
    rst = 1'b1;
    @(negedge clk); #1;
    check("reset in_ready", in_ready, 1);
    check("reset Data_MX", Data_MX, 0);
    check("reset out_result", out_result, 0);
    check("reset out_timeout", out_timeout, 0);

    // Normal op
    run_op(32'h3FC00000, 32'h40000000, 2'b00, 10, 32'h40400000, 0, 0, 0);
    check("t1 result", out_result, 32'h40400000);
    check("t1 flags", {out_overflow, out_underflow, out_timeout}, 3'b000);
    check("t1 ready-to-valid", ov_cyc - rdy_cyc, 2);
    check("t1 beg-to-ready", rdy_cyc - beg_cyc, 10);

    // Backpressure
    run_op(32'h40400000, 32'h3F800000, 2'b01, 4, 32'h12345678, 0, 0, 20);
    check("t2 result", out_result, 32'h12345678);
    check("t2 round_mode", round_mode, 2'b01);

    // Timeout
    run_op(32'h11111111, 32'h22222222, 2'b10, -1, 32'hDEADBEEF, 1, 1, 0);
    check("t3 timeout", out_timeout, 1);
    check("t3 result", out_result, 0);
    check("t3 beg-to-rst", rst_cyc - beg_cyc, 17);

    // Ready arrives on the final WAIT cycle
    run_op(32'h33333333, 32'h44444444, 2'b11, 16, 32'hC0800000, 0, 0, 0);
    check("t4 result", out_result, 32'hC0800000);
    check("t4 timeout", out_timeout, 0);
    check("t4 beg-to-rst", rst_cyc - beg_cyc, 17);

    // Flag capture
    run_op(32'h7F000000, 32'h7F000000, 2'b00, 3, 32'h7F800000, 1, 0, 0);
    check("t5 overflow", out_overflow, 1);
    check("t5 underflow", out_underflow, 0);
    check("t5 result", out_result, 32'h7F800000);
    run_op(32'h00800000, 32'h00800000, 2'b00, 5, 32'h00000000, 0, 1, 0);
    check("t5b underflow", out_underflow, 1);
    check("t5b overflow", out_overflow, 0);

    // Reset during WAIT cycle 5
    @(posedge clk); #1;
    stub_delay = 10; stub_f = 32'h55555555; stub_ov = 0; stub_un = 0;
    beg_cnt = 0; rst_cnt = 0;
    in_x = 32'hABCD0123; in_y = 32'h01234567; in_round = 2'b10; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("t6 busy before reset", busy, 1);
    rst = 1'b0;
    #1;
    check("t6 beg_FSM", beg_FSM, 0);
    check("t6 rst_FSM", rst_FSM, 0);
    check("t6 out_valid", out_valid, 0);
    check("t6 Data_MX", Data_MX, 0);
    check("t6 out_result", out_result, 0);
    check("t6 busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;
    check("t6 in_ready after release", in_ready, 1);
    check("t6 no rst pulse", rst_cnt, 0);

    run_op(32'h3FC00000, 32'h40000000, 2'b00, 10, 32'h40400000, 0, 0, 0);
    check("t6 rerun result", out_result, 32'h40400000);
    check("t6 rerun ready-to-valid", ov_cyc - rdy_cyc, 2);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
